// File: rtl/mem_if_pkg.sv
// Shared types and constants for the memory responder: FSM encoding,
// request record and default sizing.
package mem_if_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 10;
    localparam int BE_W       = 4;
    localparam int CNT_W      = 4;

    typedef struct packed {
        logic            we;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [BE_W-1:0] be;
    } req_t;
endpackage

// File: rtl/mem_responder_if.sv
// CPU memory request/response bus: valid/ready request channel and
// valid/ready response channel.
interface mem_responder_if;
    import mem_if_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic [BE_W-1:0] req_be;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_word_ram.sv
// Single-port 32-bit word RAM with per-byte write enables and a registered
// read port; contents are never reset.
module mem_word_ram
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [BE_W-1:0]   be,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W];

    for (genvar i = 0; i < BE_W; i++) begin : g_byte
        always_ff @(posedge clk) begin
            if (en && we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (en && !we) rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request, waits WAIT_CYCLES, performs the
// access (or flags an error) and holds the response until consumed.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_responder_if.slave bus
);
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt;
    req_t             req_q, cur;
    logic             err_q, live;
    logic             accept, access, cur_err;
    logic [31:0]      ram_q;

    // With zero wait states the access happens on the acceptance edge, so the
    // RAM must see the live request rather than the latched copy.
    assign cur     = (state == IDLE) ? req_t'({bus.req_we, bus.req_addr, bus.req_wdata, bus.req_be})
                                     : req_q;
    assign accept  = (state == IDLE) && live && bus.req_valid;
    assign cur_err = (cur.addr[1:0] != 2'b00) || ((cur.addr >> (ADDR_W + 2)) != 32'd0);
    assign access  = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == CNT_W'(1)));

    mem_word_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .en    (access),
        .we    (cur.we && !cur_err),
        .addr  (cur.addr[ADDR_W+1:2]),
        .wdata (cur.wdata),
        .be    (cur.be),
        .rdata (ram_q)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (accept) nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt == CNT_W'(1)) nxt = RESP;
            RESP: if (bus.rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
            err_q <= 1'b0;
            live  <= 1'b0;
        end else begin
            state <= nxt;
            live  <= 1'b1;
            if (accept) begin
                req_q <= cur;
                err_q <= cur_err;
                cnt   <= CNT_W'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Response fields are derived from registered state so they read zero
    // everywhere outside RESP and only read data ever reaches rsp_rdata.
    assign bus.req_ready = (state == IDLE) && live;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_err   = (state == RESP) && err_q;
    assign bus.rsp_rdata = ((state == RESP) && !req_q.we && !err_q) ? ram_q : 32'd0;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (2 and 0 wait states)
// driven through a shared stimulus path selected by sel.
module tb_mem_responder;
    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if b0 ();
    mem_responder_if b1 ();

    mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    bit          sel = 1'b0;
    logic        d_valid = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    bit          auto_rdy = 1'b0, man_rdy = 1'b0, rnd_rdy = 1'b0;
    logic        rdy;

    assign rdy          = auto_rdy ? rnd_rdy : man_rdy;
    assign b0.req_valid = d_valid && !sel;
    assign b1.req_valid = d_valid && sel;
    assign b0.req_we = d_we;       assign b1.req_we = d_we;
    assign b0.req_addr = d_addr;   assign b1.req_addr = d_addr;
    assign b0.req_wdata = d_wdata; assign b1.req_wdata = d_wdata;
    assign b0.req_be = d_be;       assign b1.req_be = d_be;
    assign b0.rsp_ready = rdy;     assign b1.rsp_ready = rdy;

    logic        req_ready_s, rsp_valid_s, rsp_err_s;
    logic [31:0] rsp_rdata_s;
    assign req_ready_s = sel ? b1.req_ready : b0.req_ready;
    assign rsp_valid_s = sel ? b1.rsp_valid : b0.rsp_valid;
    assign rsp_err_s   = sel ? b1.rsp_err   : b0.rsp_err;
    assign rsp_rdata_s = sel ? b1.rsp_rdata : b0.rsp_rdata;

    int          errors = 0, checks = 0;
    exp_t        sb[$];
    logic [31:0] mdl [2][DEPTH];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Reference behaviour: byte address must be word aligned and below the
    // 4 KiB window; writes merge enabled bytes, reads return the stored word.
    function automatic exp_t model(input int s, input logic we, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        if ((a % 4) != 0 || a >= 32'(4 * DEPTH)) e.err = 1'b1;
        else if (we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mdl[s][int'(a >> 2)][8*i +: 8] = wd[8*i +: 8];
        end else e.rdata = mdl[s][int'(a >> 2)];
        return e;
    endfunction

    always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid_s && rdy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata_s, e.rdata);
                    chk("rsp_err", {31'd0, rsp_err_s}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input bit upd, input bit push);
        int   n = 0;
        exp_t e;
        @(posedge clk); #1;
        while (!req_ready_s && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("req_ready_timeout", 32'd0, 32'd1);
        d_valid = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
        @(posedge clk); #1;
        d_valid = 1'b0;
        d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
        if (upd) begin
            e = model(int'(sel), we, a, wd, be);
            if (push) sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_ops(input int cnt);
        for (int k = 0; k < cnt; k++) begin
            logic [31:0] a;
            int r = $urandom_range(0, 99);
            if (r < 85)      a = 32'($urandom_range(0, 15)) << 2;
            else if (r < 93) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else             a = 32'h1000 | ($urandom & 32'hFFFF_FFFC);
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 1'b1, 1'b1);
        end
        drain();
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, b0.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, b0.rsp_valid}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_req_ready", {31'd0, b0.req_ready}, 32'd1);
        chk("idle_rsp_valid", {31'd0, b0.rsp_valid}, 32'd0);
        chk("idle_rsp_rdata", b0.rsp_rdata, 32'd0);
        chk("idle_rsp_err", {31'd0, b0.rsp_err}, 32'd0);
        chk("idle_req_ready_w0", {31'd0, b1.req_ready}, 32'd1);

        // initialise the word window of both instances
        auto_rdy = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int w = 0; w < 16; w++) issue(1'b1, 32'(w) << 2, $urandom, 4'hF, 1'b1, 1'b1);
            drain();
        end
        sel = 1'b0;

        // write then read with latency and backpressure checks
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1);
        drain();
        auto_rdy = 1'b0; man_rdy = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b1);
        @(negedge clk); chk("lat_cycle1", {31'd0, rsp_valid_s}, 32'd0);
        @(negedge clk); chk("lat_cycle2", {31'd0, rsp_valid_s}, 32'd0);
        @(negedge clk); chk("lat_cycle3", {31'd0, rsp_valid_s}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid_s}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata_s, 32'hDEAD_BEEF);
            chk("bp_rsp_err", {31'd0, rsp_err_s}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready_s}, 32'd0);
        end
        @(posedge clk); #1 man_rdy = 1'b1;
        @(posedge clk); #1 man_rdy = 1'b0;
        @(negedge clk);
        chk("post_rsp_req_ready", {31'd0, req_ready_s}, 32'd1);
        chk("post_rsp_valid", {31'd0, rsp_valid_s}, 32'd0);
        chk("post_rsp_rdata", rsp_rdata_s, 32'd0);
        drain();

        // byte enables and error cases
        auto_rdy = 1'b1;
        issue(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 1'b1, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b1);
        issue(1'b1, 32'h14, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b1);
        issue(1'b0, 32'h14, 32'h0, 4'h0, 1'b1, 1'b1);
        issue(1'b0, 32'h12, 32'h0, 4'h0, 1'b1, 1'b1);
        issue(1'b1, 32'h1000, 32'h5555_AAAA, 4'hF, 1'b1, 1'b1);
        issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
        drain();
        chk("be_merge_model", mdl[0][4], 32'hDE22_BE44);

        // randomized traffic on both instances
        rand_ops(120);
        sel = 1'b1;
        rand_ops(80);
        sel = 1'b0;

        // reset during WAIT: the write is dropped
        auto_rdy = 1'b0; man_rdy = 1'b0;
        issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", {31'd0, rsp_valid_s}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk("midrst_no_stale", {31'd0, rsp_valid_s}, 32'd0);
        end
        auto_rdy = 1'b1;
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b1);
        drain();

        // zero wait states: the write commits on acceptance, response is lost
        sel = 1'b1;
        auto_rdy = 1'b0; man_rdy = 1'b0;
        issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
        @(negedge clk);
        chk("w0_rsp_pending", {31'd0, rsp_valid_s}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("w0_midrst_rsp_valid", {31'd0, rsp_valid_s}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk("w0_midrst_no_stale", {31'd0, rsp_valid_s}, 32'd0);
        end
        auto_rdy = 1'b1;
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b1);
        drain();
        chk("w0_commit_model", mdl[1][8], 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
